// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage.
// Holds the format enum, the RV32 opcode constants and per-format register-use masks.
package id_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Bit n of each mask corresponds to format encoding n.
    localparam logic [7:0] RS1_USE_MASK = 8'b0000_1111;  // R I S B
    localparam logic [7:0] RS2_USE_MASK = 8'b0000_1101;  // R S B
    localparam logic [7:0] RD_USE_MASK  = 8'b0011_0011;  // R I U J

    function automatic logic uses_rs1(input fmt_t f);
        return RS1_USE_MASK[f];
    endfunction

    function automatic logic uses_rs2(input fmt_t f);
        return RS2_USE_MASK[f];
    endfunction

    function automatic logic uses_rd(input fmt_t f);
        return RD_USE_MASK[f];
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two async read ports, one sync write port.
// x0 reads zero and is never written; async reset clears every entry.
// Ports: i_clk, i_rst, i_we/i_waddr/i_wdata (write), i_raddr1/2 -> o_rdata1/2.
module id_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_mem [NREGS];

    // Write port; x0 is never stored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREGS); i++) r_mem[i] <= '0;
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined instruction-decode stage: decoder, immediate generator, register
// file and an ID/EX register with valid/ready handshakes, load-use stall,
// flush, operand refresh while held and illegal-instruction flagging.
// Ports: clk/rst; fetch side in_valid/in_ready/in_instr/in_pc; flush;
// writeback wb_en/wb_addr/wb_data; execute side ex_ready/out_*.
// Build option: WB_BYPASS_EN makes a same-cycle writeback visible at capture.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd_addr,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic [2:0]      out_fmt,
    output logic            out_reg_write,
    output logic            out_is_load,
    output logic            out_illegal
);

    function automatic fmt_t decode_fmt(input logic [6:0] op);
        fmt_t f;
        case (op)
            OP_REG:                              f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: f = FMT_I;
            OP_STORE:                            f = FMT_S;
            OP_BRANCH:                           f = FMT_B;
            OP_LUI, OP_AUIPC:                    f = FMT_U;
            OP_JAL:                              f = FMT_J;
            default:                             f = FMT_NONE;
        endcase
        return f;
    endfunction

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins, input fmt_t f);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (f)
            FMT_I:   imm = XLEN'($signed(ins[31:20]));
            FMT_S:   imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            FMT_B:   imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            FMT_U:   imm = XLEN'($signed({ins[31:12], 12'b0}));
            FMT_J:   imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // ID/EX register
    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]      r_rd_addr, r_rs1_addr, r_rs2_addr;
    fmt_t            r_fmt;
    logic            r_reg_write, r_is_load, r_illegal;
    logic            r_ready_en;   // low during reset and for the first cycle after it

    // Incoming-instruction decode
    logic [4:0]      w_rs1, w_rs2, w_rd;
    fmt_t            w_fmt;
    logic            w_use_rs1, w_use_rs2, w_use_rd;
    logic            w_illegal, w_stall, w_capture, w_hold;
    logic [XLEN-1:0] w_rs1_rf, w_rs2_rf, w_rs1_cap, w_rs2_cap;
    logic            w_wb_live, w_refresh1, w_refresh2;
    logic            w_unused_funct3;

    assign w_rs1     = in_instr[19:15];
    assign w_rs2     = in_instr[24:20];
    assign w_rd      = in_instr[11:7];
    assign w_fmt     = decode_fmt(in_instr[6:0]);
    assign w_use_rs1 = uses_rs1(w_fmt);
    assign w_use_rs2 = uses_rs2(w_fmt);
    assign w_use_rd  = uses_rd(w_fmt);
    assign w_unused_funct3 = ^in_instr[14:12];

    assign w_illegal = (w_fmt == FMT_NONE)
                     || (w_use_rs1 && (32'(w_rs1) >= NREGS))
                     || (w_use_rs2 && (32'(w_rs2) >= NREGS))
                     || (w_use_rd  && (32'(w_rd)  >= NREGS));

    // Load in ID/EX whose destination the incoming instruction reads.
    assign w_stall = r_valid && r_is_load && (r_rd_addr != 5'd0)
                   && ((w_use_rs1 && (w_rs1 == r_rd_addr))
                    || (w_use_rs2 && (w_rs2 == r_rd_addr)));

    assign in_ready  = r_ready_en && !flush && !w_stall && (!r_valid || ex_ready);
    assign w_capture = in_valid && in_ready;
    assign w_hold    = r_valid && !ex_ready;
    assign w_wb_live = wb_en && (wb_addr != '0);

    id_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_we     (wb_en),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data),
        .i_raddr1 (AW'(w_rs1)),
        .i_raddr2 (AW'(w_rs2)),
        .o_rdata1 (w_rs1_rf),
        .o_rdata2 (w_rs2_rf)
    );

`ifdef WB_BYPASS_EN
    // Write-through read: a same-cycle writeback wins over the stored value.
    assign w_rs1_cap = (w_wb_live && (5'(wb_addr) == w_rs1)) ? wb_data : w_rs1_rf;
    assign w_rs2_cap = (w_wb_live && (5'(wb_addr) == w_rs2)) ? wb_data : w_rs2_rf;
`else
    assign w_rs1_cap = w_rs1_rf;
    assign w_rs2_cap = w_rs2_rf;
`endif

    // Keep held operands current with writebacks to their sources.
    assign w_refresh1 = w_hold && w_wb_live && uses_rs1(r_fmt) && (5'(wb_addr) == r_rs1_addr);
    assign w_refresh2 = w_hold && w_wb_live && uses_rs2(r_fmt) && (5'(wb_addr) == r_rs2_addr);

    // ID/EX register update: flush > capture > drain > hold/refresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready_en  <= 1'b0;
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rd_addr   <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_fmt       <= FMT_NONE;
            r_reg_write <= 1'b0;
            r_is_load   <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid     <= 1'b1;
                r_pc        <= in_pc;
                r_rs1_data  <= w_rs1_cap;
                r_rs2_data  <= w_rs2_cap;
                r_imm       <= gen_imm(in_instr, w_fmt);
                r_rd_addr   <= w_rd;
                r_rs1_addr  <= w_rs1;
                r_rs2_addr  <= w_rs2;
                r_fmt       <= w_fmt;
                r_reg_write <= w_use_rd && (w_rd != 5'd0);
                r_is_load   <= (in_instr[6:0] == OP_LOAD);
                r_illegal   <= w_illegal;
            end else if (ex_ready) begin
                r_valid <= 1'b0;
            end else begin
                if (w_refresh1) r_rs1_data <= wb_data;
                if (w_refresh2) r_rs2_data <= wb_data;
            end
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign out_rs1_data  = r_rs1_data;
    assign out_rs2_data  = r_rs2_data;
    assign out_imm       = r_imm;
    assign out_rd_addr   = r_rd_addr;
    assign out_rs1_addr  = r_rs1_addr;
    assign out_rs2_addr  = r_rs2_addr;
    assign out_fmt       = r_fmt;
    assign out_reg_write = r_reg_write;
    assign out_is_load   = r_is_load;
    assign out_illegal   = r_illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a 32-register instance carries the main
// sequence, a 16-register instance sees the same stimulus for range checks.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'hFFFF_FFFF;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_ready = 1'b1;

    logic        in_ready, out_valid, out_reg_write, out_is_load, out_illegal;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rd_addr, out_rs1_addr, out_rs2_addr;
    logic [2:0]  out_fmt;

    logic        in_ready_16, out_valid_16, out_reg_write_16, out_is_load_16, out_illegal_16;
    logic [31:0] out_pc_16, out_rs1_data_16, out_rs2_data_16, out_imm_16;
    logic [4:0]  out_rd_addr_16, out_rs1_addr_16, out_rs2_addr_16;
    logic [2:0]  out_fmt_16;
    logic [3:0]  wb_addr_16;

    int n_pass  = 0;
    int n_total = 0;

    assign wb_addr_16 = wb_addr[3:0];

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rd_addr(out_rd_addr),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_fmt(out_fmt),
        .out_reg_write(out_reg_write), .out_is_load(out_is_load), .out_illegal(out_illegal)
    );

    id_stage_pipe #(.XLEN(32), .NREGS(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_16),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr_16), .wb_data(wb_data), .ex_ready(ex_ready),
        .out_valid(out_valid_16), .out_pc(out_pc_16), .out_rs1_data(out_rs1_data_16),
        .out_rs2_data(out_rs2_data_16), .out_imm(out_imm_16), .out_rd_addr(out_rd_addr_16),
        .out_rs1_addr(out_rs1_addr_16), .out_rs2_addr(out_rs2_addr_16), .out_fmt(out_fmt_16),
        .out_reg_write(out_reg_write_16), .out_is_load(out_is_load_16), .out_illegal(out_illegal_16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        tick();
    endtask

    initial begin
        // Reset with all-ones instruction on the bus
        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_fmt",   64'(out_fmt),   64'd7);
        chk("rst_imm",   64'(out_imm),   64'd0);
        chk("rst_pc",    64'(out_pc),    64'd0);
        chk("rst_rs1",   64'(out_rs1_data), 64'd0);
        chk("rst_rd",    64'(out_rd_addr),  64'd0);
        rst = 1'b0;
        tick();
        chk("rel_ready", 64'(in_ready),  64'd1);
        chk("rel_valid", 64'(out_valid), 64'd0);

        // Preload registers
        wb_write(5'd2, 32'h100);
        wb_write(5'd4, 32'h44);
        wb_write(5'd6, 32'h66);
        wb_write(5'd7, 32'h77);

        // addi x1,x2,-1
        issue(32'hfff10093, 32'h1000);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_imm",   64'(out_imm), 64'hFFFF_FFFF);
        chk("addi_fmt",   64'(out_fmt), 64'd1);
        chk("addi_rw",    64'(out_reg_write), 64'd1);
        chk("addi_rs1",   64'(out_rs1_data), 64'h100);
        chk("addi_pc",    64'(out_pc), 64'h1000);
        // sw x4,12(x1)
        issue(32'h0040a623, 32'h1004);
        chk("sw_imm",  64'(out_imm), 64'hC);
        chk("sw_fmt",  64'(out_fmt), 64'd2);
        chk("sw_rw",   64'(out_reg_write), 64'd0);
        chk("sw_rs2",  64'(out_rs2_data), 64'h44);
        chk("sw_rs1a", 64'(out_rs1_addr), 64'd1);
        // jal x1,8
        issue(32'h008000ef, 32'h1008);
        chk("jal_imm", 64'(out_imm), 64'h8);
        chk("jal_fmt", 64'(out_fmt), 64'd5);
        chk("jal_rw",  64'(out_reg_write), 64'd1);
        // lui x3,0x12345
        issue(32'h123451b7, 32'h100c);
        chk("lui_imm", 64'(out_imm), 64'h1234_5000);
        chk("lui_fmt", 64'(out_fmt), 64'd4);

        // lw x5,8(x3) then add x6,x5,x7: one bubble, with x7 written at capture
        issue(32'h0081a283, 32'h1010);
        chk("lw_load", 64'(out_is_load), 64'd1);
        chk("lw_imm",  64'(out_imm), 64'h8);
        in_instr = 32'h00728333; in_pc = 32'h1014;
        #1;
        chk("lu_stall_ready", 64'(in_ready), 64'd0);
        tick();
        chk("lu_bubble", 64'(out_valid), 64'd0);
        chk("lu_ready_after", 64'(in_ready), 64'd1);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5;
        tick();
        wb_en = 1'b0;
        chk("lu_add_valid", 64'(out_valid), 64'd1);
        chk("lu_add_rd",    64'(out_rd_addr), 64'd6);
        chk("lu_add_fmt",   64'(out_fmt), 64'd0);
        chk("lu_add_pc",    64'(out_pc), 64'h1014);
`ifdef WB_BYPASS_EN
        chk("cap_rs2_bypass", 64'(out_rs2_data), 64'hA5);
`else
        chk("cap_rs2_nobypass", 64'(out_rs2_data), 64'h77);
`endif

        // add x5,x6,x7 held, then x6 written
        issue(32'h007302b3, 32'h1018);
        chk("hold_rs1_cap", 64'(out_rs1_data), 64'h66);
        chk("hold_rs2_cap", 64'(out_rs2_data), 64'hA5);
        in_valid = 1'b0; ex_ready = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
        #1;
        chk("hold_ready", 64'(in_ready), 64'd0);
        tick();
        wb_en = 1'b0;
        chk("hold_valid",   64'(out_valid), 64'd1);
        chk("hold_refresh", 64'(out_rs1_data), 64'h55);
        chk("hold_pc",      64'(out_pc), 64'h1018);
        tick();
        chk("hold_still",   64'(out_valid), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0; ex_ready = 1'b1;
        chk("flush_valid", 64'(out_valid), 64'd0);

        // Opcode 0000000
        issue(32'h0000_0000, 32'h2000);
        chk("op0_valid",   64'(out_valid), 64'd1);
        chk("op0_fmt",     64'(out_fmt), 64'd7);
        chk("op0_illegal", 64'(out_illegal), 64'd1);
        chk("op0_rw",      64'(out_reg_write), 64'd0);

        // add x20,x1,x2: out of range only for 16 registers
        issue(32'h00208a33, 32'h2004);
        chk("x20_ill_16",   64'(out_illegal_16), 64'd1);
        chk("x20_valid_16", 64'(out_valid_16), 64'd1);
        chk("x20_ill_32",   64'(out_illegal), 64'd0);

        // Reset in the middle of a load-use stall
        issue(32'h0081a283, 32'h3000);
        in_instr = 32'h00728333; in_pc = 32'h3004;
        #1;
        chk("rs_stall_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_fmt",   64'(out_fmt), 64'd7);
        chk("rs_pc",    64'(out_pc), 64'd0);
        chk("rs_load",  64'(out_is_load), 64'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rs_ready", 64'(in_ready), 64'd1);
        issue(32'hfff10093, 32'h3008);
        chk("rs_rf_cleared", 64'(out_rs1_data), 64'd0);
        chk("rs_cap_valid",  64'(out_valid), 64'd1);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
